// File: rtl/lfsr_pkg.sv
// Shared types for the parametrised LFSR generator.
package lfsr_pkg;

  // Feedback structure selected by the runtime mode input.
  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  // Control FSM of lfsr_gen.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RECOVER = 2'd2
  } lfsr_fsm_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational multi-step LFSR advance: applies NBITS single steps to the
// current state and collects the bit shifted out of bit 0 at each step.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NBITS = 1
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  input  logic             mode,
  output logic [WIDTH-1:0] next_state,
  output logic [NBITS-1:0] bits
);

  // Unrolled chain of single steps; bit i is the LSB before step i.
  always_comb begin
    logic [WIDTH-1:0] cur;
    cur  = state;
    bits = '0;
    for (int i = 0; i < NBITS; i++) begin
      bits[i] = cur[0];
      if (mode == LFSR_GAL) begin
        cur = {1'b0, cur[WIDTH-1:1]} ^ ({WIDTH{cur[0]}} & taps);
      end else begin
        cur = {^(cur & taps), cur[WIDTH-1:1]};
      end
    end
    next_state = cur;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with valid/ready output, seed reload,
// all-zero lockup recovery, transfer counter and period-wrap pulse.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 5,
  parameter int               NBITS      = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reinit,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] taps,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [NBITS-1:0] out_bits,
  output logic [WIDTH-1:0] out_state,
  output logic             lockup,
  output logic [CNT_W-1:0] step_count,
  output logic             period_wrap
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  lfsr_fsm_e        fsm;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] loaded_seed;
  logic [WIDTH-1:0] next_state;

  // Output bits come straight from the registered state, so taps/mode
  // changes are visible on the very next step.
  lfsr_step #(
    .WIDTH (WIDTH),
    .NBITS (NBITS)
  ) u_step (
    .state      (state),
    .taps       (taps),
    .mode       (mode),
    .next_state (next_state),
    .bits       (out_bits)
  );

  assign out_state = state;

  // Control FSM plus all state registers; out_valid tracks "next FSM is RUN".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= RUN;
      state       <= RESET_SEED;
      loaded_seed <= RESET_SEED;
      step_count  <= '0;
      lockup      <= 1'b0;
      period_wrap <= 1'b0;
      out_valid   <= 1'b1;
    end else begin
      period_wrap <= 1'b0;
      case (fsm)
        RUN: begin
          if (reinit) begin
            // A reload request wins over any transfer in the same cycle.
            fsm       <= LOAD;
            out_valid <= 1'b0;
          end else if (state == '0) begin
            // All-zero state never leaves by itself; force a recovery.
            fsm       <= RECOVER;
            out_valid <= 1'b0;
          end else if (out_valid && out_ready) begin
            state       <= next_state;
            step_count  <= step_count + CNT_ONE;
            period_wrap <= (next_state == loaded_seed);
          end else begin
            state <= state;
          end
        end
        LOAD: begin
          state       <= seed;
          loaded_seed <= seed;
          step_count  <= '0;
          lockup      <= 1'b0;
          if (reinit) begin
            fsm       <= LOAD;
            out_valid <= 1'b0;
          end else begin
            fsm       <= RUN;
            out_valid <= 1'b1;
          end
        end
        RECOVER: begin
          state       <= RESET_SEED;
          loaded_seed <= RESET_SEED;
          lockup      <= 1'b1;
          if (reinit) begin
            fsm       <= LOAD;
            out_valid <= 1'b0;
          end else begin
            fsm       <= RUN;
            out_valid <= 1'b1;
          end
        end
        default: begin
          fsm         <= RUN;
          state       <= RESET_SEED;
          loaded_seed <= RESET_SEED;
          out_valid   <= 1'b1;
        end
      endcase
    end
  end

endmodule
